// File: rtl/retire_trace_buffer_pkg.sv
// Shared definitions for the retired-instruction trace buffer: record layout and FSM states.
package retire_trace_buffer_pkg;

  localparam int unsigned TRACE_REC_W = 135;

  // Bit offsets of each field inside a packed trace record (LSB positions).
  localparam int unsigned REC_MEM_ADDR_LSB = 0;
  localparam int unsigned REC_MEM_WE_BIT   = 32;
  localparam int unsigned REC_RD_DATA_LSB  = 33;
  localparam int unsigned REC_RD_ADDR_LSB  = 65;
  localparam int unsigned REC_RD_WE_BIT    = 70;
  localparam int unsigned REC_INST_LSB     = 71;
  localparam int unsigned REC_PC_LSB       = 103;

  typedef enum logic [1:0] {
    TRB_IDLE,
    TRB_ARMED,
    TRB_POST,
    TRB_FROZEN
  } trb_state_e;

  function automatic logic [TRACE_REC_W-1:0] pack_rec(
    input logic [31:0] pc,
    input logic [31:0] inst,
    input logic        rd_we,
    input logic [4:0]  rd_addr,
    input logic [31:0] rd_data,
    input logic        mem_we,
    input logic [31:0] mem_addr
  );
    return {pc, inst, rd_we, rd_addr, rd_data, mem_we, mem_addr};
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Record storage for the trace buffer: one synchronous write port, one asynchronous read port.
module trace_ram
  import retire_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned WIDTH  = TRACE_REC_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Circular capture of retired-instruction records with PC trigger, post-trigger window and
// oldest-first drain over a valid/ready port once frozen.
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned POST_COUNT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   trig_en,
  input  logic [31:0]            trig_pc,
  input  logic                   rec_valid,
  input  logic [31:0]            rec_pc,
  input  logic [31:0]            rec_inst,
  input  logic                   rec_rd_we,
  input  logic [4:0]             rec_rd_addr,
  input  logic [31:0]            rec_rd_data,
  input  logic                   rec_mem_we,
  input  logic [31:0]            rec_mem_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TRACE_REC_W-1:0] out_record,
  output logic                   busy,
  output logic                   triggered,
  output logic                   wrapped,
  output logic [ADDR_W:0]        count,
  output logic [15:0]            drop_cnt
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);
  localparam logic [15:0]     PostInit  = 16'(POST_COUNT);

  trb_state_e        state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [15:0]       post_cnt_q;
  logic [15:0]       drop_cnt_q;
  logic              triggered_q;
  logic              wrapped_q;

  logic capturing;
  logic wr_en;
  logic trig_hit;
  logic xfer;

  assign capturing = (state_q == TRB_ARMED) || (state_q == TRB_POST);
  assign wr_en     = capturing && rec_valid;
  assign trig_hit  = (state_q == TRB_ARMED) && rec_valid && trig_en && (rec_pc == trig_pc);
  assign out_valid = (state_q == TRB_FROZEN) && (count_q != '0);
  assign xfer      = out_valid && out_ready;
  // Oldest record sits count slots behind the write pointer; a full buffer gives rd == wr.
  assign rd_ptr    = wr_ptr_q - count_q[ADDR_W-1:0];

  trace_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .WIDTH (TRACE_REC_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_q),
    .wdata(pack_rec(rec_pc, rec_inst, rec_rd_we, rec_rd_addr, rec_rd_data, rec_mem_we,
                    rec_mem_addr)),
    .raddr(rd_ptr),
    .rdata(out_record)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TRB_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      post_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      triggered_q <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (count_q == FullCount) begin
          wrapped_q <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
      if (trig_hit) begin
        triggered_q <= 1'b1;
      end

      unique case (state_q)
        TRB_IDLE: begin
          if (arm) begin
            state_q     <= TRB_ARMED;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            triggered_q <= 1'b0;
            drop_cnt_q  <= '0;
          end
        end
        TRB_ARMED: begin
          // stop outranks the trigger for the state decision; triggered is still recorded.
          if (stop) begin
            state_q <= TRB_FROZEN;
          end else if (trig_hit) begin
            if (POST_COUNT == 0) begin
              state_q <= TRB_FROZEN;
            end else begin
              state_q    <= TRB_POST;
              post_cnt_q <= PostInit;
            end
          end
        end
        TRB_POST: begin
          if (stop) begin
            state_q <= TRB_FROZEN;
          end else if (rec_valid) begin
            post_cnt_q <= post_cnt_q - 16'd1;
            if (post_cnt_q == 16'd1) begin
              state_q <= TRB_FROZEN;
            end
          end
        end
        TRB_FROZEN: begin
          if (rec_valid && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
          end
          if (xfer) begin
            count_q <= count_q - 1'b1;
          end
          if ((count_q == '0) || (xfer && (count_q == (ADDR_W + 1)'(1)))) begin
            state_q <= TRB_IDLE;
          end
        end
        default: state_q <= TRB_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != TRB_IDLE);
  assign triggered = triggered_q;
  assign wrapped   = wrapped_q;
  assign count     = count_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomized scoreboard bench for retire_trace_buffer against a queue-based capture model.
module tb_retire_trace_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int POSTC  = 4;

  typedef logic [134:0] rec_t;

  localparam int M_IDLE   = 0;
  localparam int M_ARMED  = 1;
  localparam int M_POST   = 2;
  localparam int M_FROZEN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, arm, stop, trig_en, rec_valid, out_ready;
  logic [31:0] trig_pc, rec_pc, rec_inst, rec_rd_data, rec_mem_addr;
  logic        rec_rd_we, rec_mem_we;
  logic [4:0]  rec_rd_addr;
  logic        out_valid, busy, triggered, wrapped;
  rec_t        out_record;
  logic [ADDR_W:0] count;
  logic [15:0] drop_cnt;

  logic        arm0, stop0, out_ready0;
  logic        out_valid0, busy0, triggered0, wrapped0;
  rec_t        out_record0;
  logic [ADDR_W:0] count0;
  logic [15:0] drop_cnt0;

  retire_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .POST_COUNT(POSTC)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
    .rec_valid(rec_valid), .rec_pc(rec_pc), .rec_inst(rec_inst), .rec_rd_we(rec_rd_we),
    .rec_rd_addr(rec_rd_addr), .rec_rd_data(rec_rd_data), .rec_mem_we(rec_mem_we),
    .rec_mem_addr(rec_mem_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_record(out_record), .busy(busy), .triggered(triggered), .wrapped(wrapped),
    .count(count), .drop_cnt(drop_cnt)
  );

  // Second instance freezes on the trigger record itself.
  retire_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .POST_COUNT(0)) dut0 (
    .clk(clk), .rst(rst), .arm(arm0), .stop(stop0), .trig_en(trig_en), .trig_pc(trig_pc),
    .rec_valid(rec_valid), .rec_pc(rec_pc), .rec_inst(rec_inst), .rec_rd_we(rec_rd_we),
    .rec_rd_addr(rec_rd_addr), .rec_rd_data(rec_rd_data), .rec_mem_we(rec_mem_we),
    .rec_mem_addr(rec_mem_addr), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_record(out_record0), .busy(busy0), .triggered(triggered0), .wrapped(wrapped0),
    .count(count0), .drop_cnt(drop_cnt0)
  );

  int passed = 0;
  int total  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_rec(input string name, input rec_t act, input rec_t exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: the buffer is simply the last DEPTH captured records.
  int   mstate = M_IDLE;
  rec_t hist[$];
  rec_t exp_q[$];
  bit   mtrig, mwrap;
  int   mdrops, post_left, mcount;

  task automatic freeze();
    mstate = M_FROZEN;
    mcount = hist.size();
    foreach (hist[i]) exp_q.push_back(hist[i]);
  endtask

  task automatic model_reset();
    mstate = M_IDLE;
    hist.delete();
    mtrig = 0; mwrap = 0; mdrops = 0; mcount = 0;
  endtask

  task automatic model(input bit a, input bit s, input bit v, input logic [31:0] pc,
                       input bit te, input rec_t r);
    bit hit;
    case (mstate)
      M_IDLE: if (a) begin
        mstate = M_ARMED;
        hist.delete();
        mtrig = 0; mwrap = 0; mdrops = 0;
      end
      M_ARMED, M_POST: begin
        hit = (mstate == M_ARMED) && v && te && (pc == trig_pc);
        if (v) begin
          if (hist.size() == DEPTH) begin
            hist.delete(0);
            mwrap = 1;
          end
          hist.push_back(r);
        end
        if (hit) mtrig = 1;
        if (s) freeze();
        else if (hit) begin
          mstate = M_POST;
          post_left = POSTC;
        end else if (mstate == M_POST && v) begin
          post_left--;
          if (post_left == 0) freeze();
        end
      end
      default: if (v && mdrops < 65535) mdrops++;
    endcase
  endtask

  task automatic step(input bit a, input bit s, input bit v, input logic [31:0] pc,
                      input bit te, input bit rdy);
    rec_t r;
    arm = a; stop = s; rec_valid = v; rec_pc = pc; trig_en = te; out_ready = rdy;
    rec_inst     = $urandom;
    rec_rd_we    = 1'($urandom);
    rec_rd_addr  = 5'($urandom);
    rec_rd_data  = $urandom;
    rec_mem_we   = 1'($urandom);
    rec_mem_addr = $urandom;
    r = {pc, rec_inst, rec_rd_we, rec_rd_addr, rec_rd_data, rec_mem_we, rec_mem_addr};
    model(a, s, v, pc, te, r);
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check32({tag, "_count"}, 32'(count), 32'(mcount));
    check32({tag, "_wrapped"}, 32'(wrapped), 32'(mwrap));
    check32({tag, "_triggered"}, 32'(triggered), 32'(mtrig));
    check32({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(mdrops));
    check32({tag, "_busy"}, 32'(busy), 32'd1);
    check32({tag, "_out_valid"}, 32'(out_valid), 32'(mcount != 0));
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic drain(input string tag, input int mode);
    int n = 0;
    bit rdy;
    while (exp_q.size() != 0 && n < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (n % 4 == 0) || (n % 4 == 3);
        default: rdy = 1'($urandom);
      endcase
      step(0, 0, 0, 32'h0, 0, rdy);
      n++;
    end
    check32({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    step(0, 0, 0, 32'h0, 0, 1'b1);
    check32({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check32({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    mstate = M_IDLE;
    mcount = 0;
  endtask

  // Monitor: a transfer completes at the posedge following a negedge with valid && ready.
  bit   held_v = 0;
  rec_t held_rec;
  always @(negedge clk) begin
    if (rst) begin
      held_v = 0;
    end else begin
      if (held_v) begin
        check32("hold_valid", 32'(out_valid), 32'd1);
        if (out_valid) check_rec("hold_record", out_record, held_rec);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL drain_extra: got record %h, expected none", out_record);
        end else begin
          check_rec("drain_record", out_record, exp_q.pop_front());
        end
        held_v = 0;
      end else if (out_valid) begin
        held_v = 1;
        held_rec = out_record;
      end else begin
        held_v = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    arm = 0; stop = 0; trig_en = 0; trig_pc = 0; rec_valid = 0; out_ready = 0;
    rec_pc = 0; rec_inst = 0; rec_rd_we = 0; rec_rd_addr = 0; rec_rd_data = 0;
    rec_mem_we = 0; rec_mem_addr = 0; arm0 = 0; stop0 = 0; out_ready0 = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_count", 32'(count), 32'd0);
    check32("rst_out_valid", 32'(out_valid), 32'd0);
    check32("rst_triggered", 32'(triggered), 32'd0);
    check32("rst_wrapped", 32'(wrapped), 32'd0);
    check32("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // T1: five records then stop
    step(1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 32'(4 * i), 0, 0);
    step(0, 1, 0, 32'h0, 0, 0);
    check_status("t1");
    check32("t1_first_pc", out_record[134:103], 32'h0);
    drain("t1", 0);

    // T2: wrap-around
    step(1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 32'(4 * i), 0, 0);
    step(0, 1, 0, 32'h0, 0, 0);
    check_status("t2");
    check32("t2_first_pc", out_record[134:103], 32'h10);
    drain("t2", 0);

    // T3: trigger with post window, then dropped records
    trig_pc = 32'h40;
    step(1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i <= 30; i++) step(0, 0, 1, 32'(4 * i), 1, 0);
    check_status("t3");
    check32("t3_first_pc", out_record[134:103], 32'h14);
    drain("t3", 2);

    // T4: backpressure pattern during drain
    step(1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 32'(32'h200 + 4 * i), 0, 0);
    step(0, 1, 0, 32'h0, 0, 0);
    check_status("t4");
    drain("t4", 1);

    // T5: same-cycle stop and trigger
    trig_pc = 32'h100;
    step(1, 0, 0, 32'h0, 0, 0);
    step(0, 0, 1, 32'h80, 1, 0);
    step(0, 1, 1, 32'h100, 1, 0);
    check_status("t5s");
    drain("t5s", 0);

    // T5: POST_COUNT=0 instance freezes on the trigger record
    trig_pc = 32'h0;
    arm0 = 1;
    step(0, 0, 0, 32'h0, 0, 0);
    arm0 = 0;
    step(0, 0, 1, 32'h0, 1, 0);
    check32("t5_count0", 32'(count0), 32'd1);
    check32("t5_busy0", 32'(busy0), 32'd1);
    check32("t5_valid0", 32'(out_valid0), 32'd1);
    check32("t5_trig0", 32'(triggered0), 32'd1);
    check32("t5_pc0", out_record0[134:103], 32'h0);
    out_ready0 = 1;
    step(0, 0, 0, 32'h0, 0, 0);
    out_ready0 = 0;
    step(0, 0, 0, 32'h0, 0, 0);
    check32("t5_idle0", 32'(busy0), 32'd0);
    check32("t5_count0_end", 32'(count0), 32'd0);

    // T6: reset while in the post-trigger window
    trig_pc = 32'h10;
    step(1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 32'(4 * i), 1, 0);
    check32("t6_count_pre", 32'(count), 32'(hist.size()));
    check32("t6_trig_pre", 32'(triggered), 32'(mtrig));
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    check32("t6_busy", 32'(busy), 32'd0);
    check32("t6_count", 32'(count), 32'd0);
    check32("t6_valid", 32'(out_valid), 32'd0);
    step(1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'(32'h300 + 4 * i), 0, 0);
    step(0, 1, 0, 32'h0, 0, 0);
    check_status("t6");
    drain("t6", 0);

    // T7: randomized sessions
    for (int it = 0; it < 10; it++) begin
      trig_pc = 32'(4 * $urandom_range(0, 15));
      step(1, 0, 0, 32'h0, 0, 0);
      n = $urandom_range(1, 40);
      for (int j = 0; j < n && mstate != M_FROZEN; j++)
        step(0, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
             32'(4 * $urandom_range(0, 15)), 1'($urandom), 0);
      if (mstate != M_FROZEN) step(0, 1, 0, 32'h0, 0, 0);
      if (mcount > 0)
        for (int j = 0; j < 3; j++) step(0, 0, 1'($urandom), 32'h0, 0, 0);
      check_status("t7");
      drain("t7", 2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
